// File: rtl/pipe_in_check.sv
// pipe_in_check: receive-side checker for the Pipe In path.
// Regenerates the host's count/LFSR word sequence, compares it against every
// received word and keeps status for wire-out readback.
//
// Handshake: pipe_in_write qualifies pipe_in_data for exactly one cycle.
// pipe_in_ready is tied high because the checker accepts a word on every
// cycle. There is no backpressure, so a write is always accepted when reset
// is low.
module pipe_in_check #(
  parameter int CNT_W = 32,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_in_write,
  input  logic [15:0]      pipe_in_data,
  input  logic             mode,
  output logic             pipe_in_ready,
  output logic [CNT_W-1:0] word_count,
  output logic [ERR_W-1:0] error_count,
  output logic             error_flag,
  output logic [CNT_W-1:0] first_err_index,
  output logic [15:0]      first_err_expected,
  output logic [15:0]      first_err_actual,
  output logic             active,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // Polynomial x^32+x^22+x^2+1, shifting left with feedback into bit 0.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1]};
  endfunction

  logic        mode_q;
  logic [31:0] gen_lo;
  logic [31:0] gen_hi;
  logic        v1;
  logic [15:0] d1;
  logic [15:0] e1;
  state_t      state;

  assign pipe_in_ready = 1'b1;
  assign state_dbg     = state;

  // Generator: seed and latch mode during reset, advance once per accepted write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= mode;
      if (mode) begin
        gen_hi <= 32'h0D0C0B0A;
        gen_lo <= 32'h04030201;
      end else begin
        gen_hi <= 32'h00000001;
        gen_lo <= 32'h00000001;
      end
    end else if (pipe_in_write) begin
      if (mode_q) begin
        gen_hi <= lfsr_step(gen_hi);
        gen_lo <= lfsr_step(gen_lo);
      end else begin
        gen_hi <= gen_hi + 32'd1;
        gen_lo <= gen_lo + 32'd1;
      end
    end
  end

  // Stage 1: capture the received word alongside the word it should match.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      d1 <= 16'h0000;
      e1 <= 16'h0000;
    end else begin
      v1 <= pipe_in_write;
      if (pipe_in_write) begin
        d1 <= pipe_in_data;
        e1 <= gen_lo[15:0];
      end
    end
  end

  // Stage 2: compare, update counters and the IDLE/PASS/FAIL state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_IDLE;
      word_count         <= '0;
      error_count        <= '0;
      error_flag         <= 1'b0;
      active             <= 1'b0;
      first_err_index    <= '0;
      first_err_expected <= 16'h0000;
      first_err_actual   <= 16'h0000;
    end else if (v1) begin
      word_count <= word_count + CNT_ONE;
      active     <= 1'b1;
      if (d1 != e1) begin
        if (error_count != ERR_MAX) begin
          error_count <= error_count + ERR_ONE;
        end
        // Only the first mismatch is recorded; FAIL is absorbing until reset.
        if (!error_flag) begin
          error_flag         <= 1'b1;
          first_err_index    <= word_count;
          first_err_expected <= e1;
          first_err_actual   <= d1;
        end
        state <= ST_FAIL;
      end else if (state == ST_IDLE) begin
        state <= ST_PASS;
      end
    end
  end

endmodule
